// File: rtl/fpu_pkg.sv
// Shared binary32 field constants, FCLASS bit positions and operation tags
// for the FPU operand path.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int SIG_W  = MAN_W + 1;
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int CLS_W  = 10;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  typedef enum logic [1:0] {
    FUNC_LE = 2'b00,
    FUNC_LT = 2'b01,
    FUNC_EQ = 2'b10
  } comp_func_e;

  typedef struct packed {
    logic exp_zero;
    logic exp_ones;
    logic man_zero;
    logic man_msb;
  } pred_t;

  function automatic pred_t operand_pred(input logic [WORD_W-1:0] x);
    pred_t p;
    p.exp_zero = (x[MAN_W +: EXP_W] == '0);
    p.exp_ones = (x[MAN_W +: EXP_W] == EXP_MAX);
    p.man_zero = (x[MAN_W-1:0] == '0);
    p.man_msb  = x[MAN_W-1];
    return p;
  endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational classifier: turns registered field predicates of one operand
// into significand, NaN/zero/sNaN flags and the one-hot FCLASS mask.
module fpu_classify
  import fpu_pkg::*;
(
  input  logic             sign,
  input  pred_t            pred,
  input  logic [MAN_W-1:0] man,
  output logic [SIG_W-1:0] sig,
  output logic             is_nan,
  output logic             is_zero,
  output logic             is_snan,
  output logic [CLS_W-1:0] cls
);

  always_comb begin
    sig     = {!pred.exp_zero, man};
    is_nan  = pred.exp_ones && !pred.man_zero;
    is_zero = pred.exp_zero && pred.man_zero;
    is_snan = is_nan && !pred.man_msb;
    cls     = '0;
    // NaN classes ignore sign; subnormals keep a zero exponent and hidden bit.
    if (is_nan)
      cls[pred.man_msb ? CLS_QNAN : CLS_SNAN] = 1'b1;
    else if (pred.exp_ones)
      cls[sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
    else if (is_zero)
      cls[sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
    else if (pred.exp_zero)
      cls[sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
    else
      cls[sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
  end

endmodule

// File: rtl/fpu_operand_unpack.sv
// Two-stage valid/ready operand unpacker: S1 captures raw operands plus field
// predicates, S2 registers the classified fields that feed the FPU datapath.
module fpu_operand_unpack
  import fpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] op_a_i,
  input  logic [WORD_W-1:0] op_b_i,
  input  logic [1:0]        func_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        func_o,
  output logic              sign_a_o,
  output logic              sign_b_o,
  output logic [EXP_W-1:0]  exp_a_o,
  output logic [EXP_W-1:0]  exp_b_o,
  output logic [SIG_W-1:0]  sig_a_o,
  output logic [SIG_W-1:0]  sig_b_o,
  output logic              is_nan_a_o,
  output logic              is_nan_b_o,
  output logic              is_zero_a_o,
  output logic              is_zero_b_o,
  output logic              is_signaling_o,
  output logic [CLS_W-1:0]  class_a_o,
  output logic [CLS_W-1:0]  class_b_o
);

  logic              vld_p1, vld_p2;
  logic              adv1, adv2;
  logic [WORD_W-1:0] op_a_p1, op_b_p1;
  logic [1:0]        func_p1;
  pred_t             pred_a_p1, pred_b_p1;

  logic [SIG_W-1:0]  sig_a, sig_b;
  logic              nan_a, nan_b, zero_a, zero_b, snan_a, snan_b;
  logic [CLS_W-1:0]  cls_a, cls_b;

  // An empty stage always advances, so bubbles collapse under backpressure.
  assign adv2        = !vld_p2 || out_ready_i;
  assign adv1        = !vld_p1 || adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = vld_p2;

  // ---- S1: raw operands and field predicates
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1    <= 1'b0;
      op_a_p1   <= '0;
      op_b_p1   <= '0;
      func_p1   <= '0;
      pred_a_p1 <= '0;
      pred_b_p1 <= '0;
    end else if (adv1) begin
      vld_p1 <= in_valid_i;
      if (in_valid_i) begin
        op_a_p1   <= op_a_i;
        op_b_p1   <= op_b_i;
        func_p1   <= func_i;
        pred_a_p1 <= operand_pred(op_a_i);
        pred_b_p1 <= operand_pred(op_b_i);
      end
    end
  end

  fpu_classify u_cls_a (
    .sign    (op_a_p1[WORD_W-1]),
    .pred    (pred_a_p1),
    .man     (op_a_p1[MAN_W-1:0]),
    .sig     (sig_a),
    .is_nan  (nan_a),
    .is_zero (zero_a),
    .is_snan (snan_a),
    .cls     (cls_a)
  );

  fpu_classify u_cls_b (
    .sign    (op_b_p1[WORD_W-1]),
    .pred    (pred_b_p1),
    .man     (op_b_p1[MAN_W-1:0]),
    .sig     (sig_b),
    .is_nan  (nan_b),
    .is_zero (zero_b),
    .is_snan (snan_b),
    .cls     (cls_b)
  );

  // ---- S2: classified fields, driven straight to the outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p2         <= 1'b0;
      func_o         <= '0;
      sign_a_o       <= 1'b0;
      sign_b_o       <= 1'b0;
      exp_a_o        <= '0;
      exp_b_o        <= '0;
      sig_a_o        <= '0;
      sig_b_o        <= '0;
      is_nan_a_o     <= 1'b0;
      is_nan_b_o     <= 1'b0;
      is_zero_a_o    <= 1'b0;
      is_zero_b_o    <= 1'b0;
      is_signaling_o <= 1'b0;
      class_a_o      <= '0;
      class_b_o      <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        func_o         <= func_p1;
        sign_a_o       <= op_a_p1[WORD_W-1];
        sign_b_o       <= op_b_p1[WORD_W-1];
        exp_a_o        <= op_a_p1[MAN_W +: EXP_W];
        exp_b_o        <= op_b_p1[MAN_W +: EXP_W];
        sig_a_o        <= sig_a;
        sig_b_o        <= sig_b;
        is_nan_a_o     <= nan_a;
        is_nan_b_o     <= nan_b;
        is_zero_a_o    <= zero_a;
        is_zero_b_o    <= zero_b;
        is_signaling_o <= snan_a || snan_b;
        class_a_o      <= cls_a;
        class_b_o      <= cls_b;
      end
    end
  end

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Bench for fpu_operand_unpack: directed vectors with hand-computed fields,
// backpressure, random streaming against a reference model, mid-flight reset.
module tb_fpu_operand_unpack;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] op_a_i, op_b_i;
  logic [1:0]  func_i, func_o;
  logic        sign_a_o, sign_b_o;
  logic [7:0]  exp_a_o, exp_b_o;
  logic [23:0] sig_a_o, sig_b_o;
  logic        is_nan_a_o, is_nan_b_o, is_zero_a_o, is_zero_b_o, is_signaling_o;
  logic [9:0]  class_a_o, class_b_o;

  logic [44:0] bundle_a, bundle_b;
  int          n_chk = 0, n_err = 0, n_acc = 0, n_out = 0;
  logic        acc;
  logic [65:0] q[$];

  always #5 clk = ~clk;

  fpu_operand_unpack dut (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .func_i(func_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .func_o(func_o),
    .sign_a_o(sign_a_o), .sign_b_o(sign_b_o), .exp_a_o(exp_a_o), .exp_b_o(exp_b_o),
    .sig_a_o(sig_a_o), .sig_b_o(sig_b_o), .is_nan_a_o(is_nan_a_o), .is_nan_b_o(is_nan_b_o),
    .is_zero_a_o(is_zero_a_o), .is_zero_b_o(is_zero_b_o), .is_signaling_o(is_signaling_o),
    .class_a_o(class_a_o), .class_b_o(class_b_o)
  );

  assign bundle_a = {sign_a_o, exp_a_o, sig_a_o, is_nan_a_o, is_zero_a_o, class_a_o};
  assign bundle_b = {sign_b_o, exp_b_o, sig_b_o, is_nan_b_o, is_zero_b_o, class_b_o};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] ref_class(input logic [31:0] x);
    logic [7:0]  e = x[30:23];
    logic [22:0] m = x[22:0];
    if (e == 8'hFF && m != 0) return m[22] ? 10'h200 : 10'h100;
    if (e == 8'hFF)           return x[31] ? 10'h001 : 10'h080;
    if (e == 0 && m == 0)     return x[31] ? 10'h008 : 10'h010;
    if (e == 0)               return x[31] ? 10'h004 : 10'h020;
    return x[31] ? 10'h002 : 10'h040;
  endfunction

  function automatic logic [44:0] ref_bundle(input logic [31:0] x);
    logic [9:0] c = ref_class(x);
    return {x[31], x[30:23], (x[30:23] != 8'h00), x[22:0], (c[8] | c[9]), (c[3] | c[4]), c};
  endfunction

  function automatic logic ref_snan(input logic [31:0] x);
    logic [9:0] c = ref_class(x);
    return c[8];
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: begin r[30:23] = 8'h00; r[22:0] = '0; end
      3: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      default: ;
    endcase
    return r;
  endfunction

  // One clock: sample handshakes at the falling edge, score outputs, then
  // return 1 time unit after the rising edge.
  task automatic step();
    logic [65:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (!reset_i) begin
      if (out_valid_o && out_ready_i) begin
        n_out++;
        if (q.size() == 0) chk("sb_extra", 64'(1), 64'(0));
        else begin
          e = q.pop_front();
          chk("sb_a", 64'(bundle_a), 64'(ref_bundle(e[63:32])));
          chk("sb_b", 64'(bundle_b), 64'(ref_bundle(e[31:0])));
          chk("sb_fs", 64'({func_o, is_signaling_o}),
              64'({e[65:64], ref_snan(e[63:32]) | ref_snan(e[31:0])}));
        end
      end
      if (in_valid_i && in_ready_o) begin
        acc = 1'b1;
        n_acc++;
        q.push_back({func_i, op_a_i, op_b_i});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk(tag, 64'(q.size()), 64'(0));
  endtask

  // Present one pair, check two-cycle latency; leaves the result on the outputs.
  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    op_a_i = a; op_b_i = b; func_i = f;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    step();
    chk("dir_acc", 64'(acc), 64'(1));
    in_valid_i = 1'b0;
    chk("dir_lat1", 64'(out_valid_o), 64'(0));
    step();
    chk("dir_lat2", 64'(out_valid_o), 64'(1));
  endtask

  initial begin
    int base_acc, base_out, i, cyc;
    logic [31:0] ca, cb;
    reset_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b0;
    op_a_i = 32'h3F800000; op_b_i = 32'h3F800000; func_i = 2'b00;
    repeat (3) step();
    chk("rst_a", 64'(bundle_a), 64'(0));
    chk("rst_b", 64'(bundle_b), 64'(0));
    chk("rst_misc", 64'({out_valid_o, func_o, is_signaling_o}), 64'(0));
    reset_i = 1'b0; in_valid_i = 1'b0;
    chk("rst_rdy", 64'(in_ready_o), 64'(1));

    dir(32'h3F800000, 32'hC0000000, FUNC_LT);
    chk("nrm_a", 64'({sign_a_o, exp_a_o, sig_a_o, class_a_o}), {29'd0, 1'b0, 8'h7F, 24'h800000, 10'h040});
    chk("nrm_b", 64'({sign_b_o, exp_b_o, sig_b_o, class_b_o}), {29'd0, 1'b1, 8'h80, 24'h800000, 10'h002});
    chk("nrm_fs", 64'({func_o, is_signaling_o}), 64'(3'b010));
    step();

    dir(32'h7F800001, 32'h7FC00000, FUNC_EQ);
    chk("nan_flags", 64'({is_nan_a_o, is_nan_b_o, is_signaling_o}), 64'(3'b111));
    chk("nan_cls", 64'({class_a_o, class_b_o}), 64'({10'h100, 10'h200}));
    step();

    dir(32'h80000000, 32'h00000001, FUNC_LE);
    chk("zero_a", 64'({class_a_o, is_zero_a_o}), 64'({10'h008, 1'b1}));
    chk("sub_b", 64'({class_b_o, sig_b_o, exp_b_o}), 64'({10'h020, 24'h000001, 8'h00}));
    step();

    dir(32'hFF800000, 32'h7F800000, FUNC_LE);
    chk("inf", 64'({class_a_o, is_nan_a_o, class_b_o, is_nan_b_o}), 64'({10'h001, 1'b0, 10'h080, 1'b0}));
    step();
    drain("dir_drain");

    // Backpressure: only two pairs fit while the consumer stalls.
    base_acc = n_acc; base_out = n_out;
    out_ready_i = 1'b0; in_valid_i = 1'b1; func_i = FUNC_LT;
    op_a_i = 32'h41200000; op_b_i = 32'h80000001; step();
    op_a_i = 32'hC2C80000; op_b_i = 32'h00000000; step();
    op_a_i = 32'h7F800000; op_b_i = 32'hFFC00001;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rdy", 64'(in_ready_o), 64'(0));
      step();
    end
    chk("bp_cnt", 64'(n_acc - base_acc), 64'(2));
    chk("bp_hold_a", 64'({out_valid_o, bundle_a}), 64'({1'b1, ref_bundle(32'h41200000)}));
    chk("bp_hold_b", 64'(bundle_b), 64'(ref_bundle(32'h80000001)));
    out_ready_i = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) step();
    drain("bp_drain");
    chk("bp_out", 64'(n_out - base_out), 64'(3));

    // Random streaming with random consumer stalls.
    base_out = n_out; i = 0; cyc = 0;
    ca = rnd_op(); cb = rnd_op();
    while (i < 100 && cyc < 3000) begin
      op_a_i = ca; op_b_i = cb; func_i = 2'($urandom_range(0, 3));
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = $urandom_range(0, 1) == 1;
      step();
      cyc++;
      if (acc) begin i++; ca = rnd_op(); cb = rnd_op(); end
    end
    chk("str_sent", 64'(i), 64'(100));
    drain("str_drain");
    chk("str_out", 64'(n_out - base_out), 64'(100));

    // Full throughput while the consumer is always ready.
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      op_a_i = rnd_op(); op_b_i = rnd_op(); func_i = FUNC_EQ;
      step();
      chk("thru", 64'(acc), 64'(1));
    end
    drain("thru_drain");

    // Reset with both stages full.
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    op_a_i = 32'hBF800000; op_b_i = 32'h7F800001; func_i = FUNC_LT; step();
    op_a_i = 32'h00000000; op_b_i = 32'hFF800000; step();
    chk("mf_full", 64'({out_valid_o, in_ready_o}), 64'(2'b10));
    reset_i = 1'b1;
    step();
    chk("mf_a", 64'(bundle_a), 64'(0));
    chk("mf_b", 64'(bundle_b), 64'(0));
    chk("mf_misc", 64'({out_valid_o, func_o, is_signaling_o}), 64'(0));
    q.delete();
    step();
    reset_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    step(); step();
    chk("mf_ign", 64'(out_valid_o), 64'(0));
    dir(32'h40490FDB, 32'h00400000, FUNC_EQ);
    chk("mf_post_a", 64'({sign_a_o, exp_a_o, sig_a_o, class_a_o}), {29'd0, 1'b0, 8'h80, 24'hC90FDB, 10'h040});
    chk("mf_post_b", 64'({exp_b_o, sig_b_o, class_b_o, func_o}), {20'd0, 8'h00, 24'h400000, 10'h020, 2'b10});
    step();
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
